// File: rtl/tx_dump_if.sv
// tx_dump_if -- bundle of the receive/key/transmit handshakes and the
// buffer-RAM / status outputs of tx_dump_ctrl.
//   master : the controller side (drives wren, addresses, send_en, status)
//   slave  : the environment side (drives rx_done, key_*, tx_done)
// Signals:
//   rx_done   one-cycle pulse, received byte valid at RAM data input
//   key_flag  debounced key event strobe
//   key_state debounced key level (press = key_flag & ~key_state)
//   tx_done   one-cycle pulse, transmitter finished a byte
//   wren / wraddress  RAM write strobe and address
//   rdaddress RAM read address
//   send_en   one-cycle transmitter start pulse
//   fill      bytes stored and not yet sent (0 .. 2^ADDR_W)
//   empty / full / overflow / busy  status flags
interface tx_dump_if #(
  parameter int ADDR_W = 8
);
  logic              rx_done;
  logic              key_flag;
  logic              key_state;
  logic              tx_done;
  logic              wren;
  logic [ADDR_W-1:0] wraddress;
  logic [ADDR_W-1:0] rdaddress;
  logic              send_en;
  logic [ADDR_W:0]   fill;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              busy;

  modport master (
    input  rx_done, key_flag, key_state, tx_done,
    output wren, wraddress, rdaddress, send_en, fill,
           empty, full, overflow, busy
  );

  modport slave (
    output rx_done, key_flag, key_state, tx_done,
    input  wren, wraddress, rdaddress, send_en, fill,
           empty, full, overflow, busy
  );
endinterface

// File: rtl/tx_dump_ctrl.sv
// tx_dump_ctrl -- stores received bytes into a circular buffer RAM and,
// while the run flag is set (toggled by key presses), reads them back one
// at a time and hands each to a UART transmitter.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    tx_dump_if.master (handshakes, RAM addresses, status flags)
// Parameters: ADDR_W (buffer depth 2^ADDR_W), RD_LAT (RAM read latency,
// 1..4), GAP_CYCLES (idle cycles between bytes, TX_GAP_EN builds only).
// Optional feature: define TX_GAP_EN to insert GAP_CYCLES idle cycles
// after every completed byte before the next byte is considered.
module tx_dump_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int RD_LAT     = 2,
  parameter int GAP_CYCLES = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  tx_dump_if.master bus
);
  localparam int              DEPTH_I  = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH    = DEPTH_I[ADDR_W:0];
  localparam logic [ADDR_W:0] FILL_ONE = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [2:0]      RD_LAST  = 3'(RD_LAT - 1);

`ifdef TX_GAP_EN
  localparam int             GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  typedef enum logic [2:0] {IDLE, READ, SEND, WAIT, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, SEND, WAIT} state_t;
`endif

  state_t            r_state, w_state_nxt;
  logic              r_run;
  logic              r_ovf;
  logic [ADDR_W-1:0] r_wraddr;
  logic [ADDR_W-1:0] r_rdaddr;
  logic [ADDR_W:0]   r_fill;
  logic [ADDR_W:0]   w_fill_nxt;
  logic [2:0]        r_rd_cnt, w_rd_cnt_nxt;
`ifdef TX_GAP_EN
  logic [GAP_W-1:0]  r_gap_cnt, w_gap_cnt_nxt;
`endif
  logic w_full, w_empty, w_wr, w_done, w_press, w_send, w_go_on;

  assign w_full  = (r_fill == DEPTH);
  assign w_empty = (r_fill == '0);
  assign w_wr    = bus.rx_done & ~w_full;
  assign w_press = bus.key_flag & ~bus.key_state;
  // A completion only counts while actually waiting for the transmitter.
  assign w_done  = (r_state == WAIT) & bus.tx_done;

  always_comb begin
    case ({w_wr, w_done})
      2'b10:   w_fill_nxt = r_fill + FILL_ONE;
      2'b01:   w_fill_nxt = r_fill - FILL_ONE;
      default: w_fill_nxt = r_fill;
    endcase
  end

  // Continue with another byte only if still running and something remains
  // once this cycle's write/completion has been accounted for.
  assign w_go_on = r_run && (w_fill_nxt != '0);

  always_comb begin
    w_state_nxt  = r_state;
    w_rd_cnt_nxt = r_rd_cnt;
`ifdef TX_GAP_EN
    w_gap_cnt_nxt = r_gap_cnt;
`endif
    w_send = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_run && !w_empty) begin
          w_state_nxt  = READ;
          w_rd_cnt_nxt = '0;
        end
      end
      READ: begin
        if (r_rd_cnt == RD_LAST) w_state_nxt = SEND;
        else                     w_rd_cnt_nxt = r_rd_cnt + 3'd1;
      end
      SEND: begin
        w_send      = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.tx_done) begin
`ifdef TX_GAP_EN
          w_state_nxt   = GAP;
          w_gap_cnt_nxt = '0;
`else
          w_state_nxt  = w_go_on ? READ : IDLE;
          w_rd_cnt_nxt = '0;
`endif
        end
      end
`ifdef TX_GAP_EN
      GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt  = w_go_on ? READ : IDLE;
          w_rd_cnt_nxt = '0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_ONE;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_run    <= 1'b0;
      r_ovf    <= 1'b0;
      r_wraddr <= '0;
      r_rdaddr <= '0;
      r_fill   <= '0;
      r_rd_cnt <= '0;
`ifdef TX_GAP_EN
      r_gap_cnt <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_rd_cnt <= w_rd_cnt_nxt;
`ifdef TX_GAP_EN
      r_gap_cnt <= w_gap_cnt_nxt;
`endif
      r_run  <= r_run ^ w_press;
      r_fill <= w_fill_nxt;
      // A dropped byte in the same cycle as a press still flags overflow.
      if (bus.rx_done && w_full) r_ovf <= 1'b1;
      else if (w_press)          r_ovf <= 1'b0;
      if (w_wr)   r_wraddr <= r_wraddr + ADDR_ONE;
      if (w_done) r_rdaddr <= r_rdaddr + ADDR_ONE;
    end
  end

  assign bus.wren      = w_wr;
  assign bus.wraddress = r_wraddr;
  assign bus.rdaddress = r_rdaddr;
  assign bus.send_en   = w_send;
  assign bus.fill      = r_fill;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.overflow  = r_ovf;
  assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_tx_dump_ctrl.sv
module tb_tx_dump_ctrl;
  localparam int AW    = 2;
  localparam int RDL   = 2;
  localparam int GAPC  = 16;
  localparam int DEPTH = 1 << AW;
`ifdef TX_GAP_EN
  localparam int EXP_LAT = GAPC + RDL + 1;
`else
  localparam int EXP_LAT = RDL + 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tx_dump_if #(.ADDR_W(AW)) bus ();
  tx_dump_ctrl #(.ADDR_W(AW), .RD_LAT(RDL), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int tx_due = -1;
  int tx_dly = 10;
  bit spur_td = 1'b0;
  int n_send = 0;
  int n_wren = 0;
  int send_cyc[$];
  int ra_at_send[$];

  // Reference model: byte counter, pointers, run/overflow flags and a
  // schedule of "cycles until the next start pulse".
  bit m_valid = 1'b0;
  bit m_run, m_ovf, m_busy;
  int m_fill, m_wa, m_ra;
  int m_left;  // >0: read cycles left, 0: start-pulse cycle, -1: awaiting done
  int m_gap;   // remaining idle cycles after a completion

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic decide(input int f);
    m_gap = 0;
    if (m_run && f != 0) m_left = RDL;
    else begin
      m_busy = 1'b0;
      m_left = 0;
    end
  endtask

  task automatic tick();
    bit rx, press, td, wr, done, full;
    int fill_new;
    bus.tx_done = (cyc == tx_due) || spur_td;
    #1;
    rx    = bus.rx_done;
    press = bus.key_flag && !bus.key_state;
    td    = bus.tx_done;
    full  = (m_fill == DEPTH);
    wr    = rx && !full;
    if (m_valid) begin
      chk("wren", bus.wren, wr);
      chk("wraddress", bus.wraddress, m_wa);
      chk("rdaddress", bus.rdaddress, m_ra);
      chk("send_en", bus.send_en, m_busy && m_left == 0);
      chk("fill", bus.fill, m_fill);
      chk("empty", bus.empty, m_fill == 0);
      chk("full", bus.full, full);
      chk("overflow", bus.overflow, m_ovf);
      chk("busy", bus.busy, m_busy);
    end
    if (bus.send_en === 1'b1) begin
      n_send++;
      send_cyc.push_back(cyc);
      ra_at_send.push_back(int'(bus.rdaddress));
      tx_due = cyc + tx_dly;
    end
    if (bus.wren === 1'b1) n_wren++;
    if (!rst_n) begin
      m_valid = 1'b1;
      m_run = 0; m_ovf = 0; m_busy = 0;
      m_fill = 0; m_wa = 0; m_ra = 0; m_left = 0; m_gap = 0;
    end else if (m_valid) begin
      done     = m_busy && m_left == -1 && m_gap == 0 && td;
      fill_new = m_fill + int'(wr) - int'(done);
      if (!m_busy) begin
        if (m_run && m_fill != 0) begin
          m_busy = 1'b1;
          m_left = RDL;
        end
      end else if (m_gap > 0) begin
        if (m_gap == 1) decide(fill_new);
        else m_gap--;
      end else if (m_left > 0) m_left--;
      else if (m_left == 0) m_left = -1;
      else if (done) begin
`ifdef TX_GAP_EN
        m_gap = GAPC;
`else
        decide(fill_new);
`endif
      end
      if (rx && full) m_ovf = 1'b1;
      else if (press) m_ovf = 1'b0;
      m_run  = m_run ^ press;
      m_wa   = (m_wa + int'(wr)) % DEPTH;
      m_ra   = (m_ra + int'(done)) % DEPTH;
      m_fill = fill_new;
    end
    @(negedge clk);
    cyc++;
    bus.rx_done   = 1'b0;
    bus.key_flag  = 1'b0;
    bus.key_state = 1'b1;
    spur_td       = 1'b0;
    rst_n         = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic press();
    bus.key_flag  = 1'b1;
    bus.key_state = 1'b0;
    tick();
  endtask

  task automatic write_n(input int n);
    for (int k = 0; k < n; k++) begin
      bus.rx_done = 1'b1;
      tick();
    end
  endtask

  task automatic wait_send(input string nm, input int budget);
    int start;
    int k;
    start = n_send;
    k = 0;
    while (n_send == start && k < budget) begin
      tick();
      k++;
    end
    chk(nm, n_send - start, 1);
  endtask

  int s0, w0;

  initial begin
    rst_n = 1'b0;
    bus.rx_done = 1'b0; bus.key_flag = 1'b0; bus.key_state = 1'b1; bus.tx_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; tick();
    rst_n = 1'b0; tick();
    #1;
    chk("rst_fill", bus.fill, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovf", bus.overflow, 0);

    // Three bytes, one press, transmitter answers 10 cycles after each start.
    tx_dly = 10;
    send_cyc.delete(); ra_at_send.delete();
    s0 = n_send;
    write_n(3);
    #1 chk("s1_wraddr", bus.wraddress, 3);
    press();
    ticks(100);
    #1;
    chk("s1_sends", n_send - s0, 3);
    chk("s1_ra0", ra_at_send.size() > 0 ? ra_at_send[0] : -1, 0);
    chk("s1_ra1", ra_at_send.size() > 1 ? ra_at_send[1] : -1, 1);
    chk("s1_ra2", ra_at_send.size() > 2 ? ra_at_send[2] : -1, 2);
    chk("s1_rdaddr", bus.rdaddress, 3);
    chk("s1_fill", bus.fill, 0);
    chk("s1_busy", bus.busy, 0);
    press();

    // Five writes into a 4-deep buffer while stopped.
    w0 = n_wren;
    write_n(5);
    #1;
    chk("s2_wren", n_wren - w0, 4);
    chk("s2_fill", bus.fill, 4);
    chk("s2_full", bus.full, 1);
    chk("s2_ovf", bus.overflow, 1);
    press();
    #1 chk("s2_ovf_clr", bus.overflow, 0);
    ticks(120);
    #1 chk("s2_fill_end", bus.fill, 0);
    press();

    // Write and completion in the same cycle with two bytes pending.
    write_n(2);
    press();
    wait_send("s3_first_send", 50);
    tx_due = -1;
    ticks(3);
    #1;
    chk("s3_fill_pre", bus.fill, 2);
    chk("s3_wa_pre", bus.wraddress, 1);
    chk("s3_ra_pre", bus.rdaddress, 3);
    bus.rx_done = 1'b1;
    spur_td = 1'b1;
    tick();
    #1;
    chk("s3_fill", bus.fill, 2);
    chk("s3_wa", bus.wraddress, 2);
    chk("s3_ra", bus.rdaddress, 0);
    ticks(100);
    #1 chk("s3_fill_end", bus.fill, 0);
    press();

    // Stop request while the first of four bytes is in flight.
    write_n(4);
    press();
    wait_send("s4_first_send", 50);
    s0 = n_send;
    ticks(3);
    press();
    ticks(60);
    #1;
    chk("s4_sends", n_send - s0, 0);
    chk("s4_fill", bus.fill, 3);
    chk("s4_busy", bus.busy, 0);
    press();
    ticks(100);
    press();

    // Reset pulse during the read phase.
    write_n(1);
    press();
    tick();
    #1 chk("s5_busy_read", bus.busy, 1);
    rst_n = 1'b0;
    tick();
    #1;
    chk("s5_fill", bus.fill, 0);
    chk("s5_empty", bus.empty, 1);
    chk("s5_busy", bus.busy, 0);
    chk("s5_wa", bus.wraddress, 0);
    chk("s5_ra", bus.rdaddress, 0);
    chk("s5_send_en", bus.send_en, 0);
    s0 = n_send;
    ticks(30);
    chk("s5_no_send", n_send - s0, 0);

    // Completion-to-next-start latency.
    tx_due = -1;
    write_n(2);
    press();
    wait_send("s6_send1", 50);
    wait_send("s6_send2", 100);
    chk("s6_latency", send_cyc[send_cyc.size()-1] - send_cyc[send_cyc.size()-2] - tx_dly, EXP_LAT);
    ticks(80);
    press();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      bus.rx_done = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 99);
      if (r < 2) begin bus.key_flag = 1'b1; bus.key_state = 1'b0; end
      else if (r < 4) begin bus.key_flag = 1'b1; bus.key_state = 1'b1; end
      else if (r < 6) bus.key_state = 1'b0;
      spur_td = ($urandom_range(0, 39) == 0);
      tx_dly = $urandom_range(1, 15);
      if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
